// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared duty width, ramp state encoding and saturating magnitude helper.
package pwm_ctrl_pkg;
   localparam int DUTY_W = 16;
   typedef enum logic {RUN, DEAD} state_t;
   // Magnitude is formed in DUTY_W+1 bits so the most negative command yields 2^(DUTY_W-1) before clamping.
   function automatic logic [DUTY_W-1:0] sat_abs(input logic signed [DUTY_W-1:0] v, input logic [DUTY_W-1:0] mx);
      logic [DUTY_W:0] a;
      a = v[DUTY_W-1] ? -{v[DUTY_W-1], v} : {1'b0, v};
      return a > {1'b0, mx} ? mx : a[DUTY_W-1:0];
   endfunction
endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// pwm_ramp_ctrl_if: valid/ready speed command channel from the command source into the ramp controller.
interface pwm_ramp_ctrl_if;
   import pwm_ctrl_pkg::*;
   logic cmd_valid;
   logic cmd_ready;
   logic signed [DUTY_W-1:0] cmd_speed;
   modport master(output cmd_valid, cmd_speed, input cmd_ready);
   modport slave(input cmd_valid, cmd_speed, output cmd_ready);
endinterface

// File: rtl/ramp_tick_gen.sv
// ramp_tick_gen: free-running prescaler emitting a one-clock tick every TICK_DIV clocks.
module ramp_tick_gen #(
   parameter int TICK_DIV = 1000
) (
   input  logic CLK100MHZ,
   input  logic rst,
   output logic tick
);
   localparam int W = $clog2(TICK_DIV + 1);
   logic [W-1:0] cnt;
   assign tick = cnt == W'(TICK_DIV - 1);
   always_ff @(posedge CLK100MHZ or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: slew-limited duty/direction sequencer with dead time on reversal and estop.
// Optional command watchdog enabled by defining PWM_RAMP_WDOG_EN.
module pwm_ramp_ctrl import pwm_ctrl_pkg::*; #(
   parameter int STEP = 4,
   parameter int TICK_DIV = 1000,
   parameter int DEAD_CYCLES = 100,
   parameter logic [DUTY_W-1:0] DUTY_MAX = 16'hFFFF
`ifdef PWM_RAMP_WDOG_EN
   , parameter int WDOG_CYCLES = 1_000_000
`endif
) (
   input  logic              CLK100MHZ,
   input  logic              rst,
   pwm_ramp_ctrl_if.slave    cmd,
   input  logic              estop,
   output logic [DUTY_W-1:0] duty_out,
   output logic              dir_out,
   output logic              at_target,
   output logic              busy,
   output logic              wdog_fault
);
   localparam int DW = $clog2(DEAD_CYCLES + 1);
   localparam logic [DUTY_W:0] ST = (DUTY_W + 1)'(STEP);
   state_t state, state_nx;
   logic [DUTY_W-1:0] tgt_mag, tgt_mag_nx, duty_nx, up_v, dn_v, dz_v;
   logic tgt_dir, tgt_dir_nx, dir_nx, tick, accept, wdog_hit;
   logic [DW-1:0] dead_cnt, dead_nx;
   ramp_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.CLK100MHZ(CLK100MHZ), .rst(rst), .tick(tick));
   assign cmd.cmd_ready = state == RUN && !estop;
   assign accept = cmd.cmd_valid && cmd.cmd_ready;
   assign at_target = state == RUN && duty_out == tgt_mag && dir_out == tgt_dir;
   assign busy = !at_target;
   // Ramp candidates computed one bit wider so neither direction can wrap past the target or zero.
   assign up_v = {1'b0, duty_out} + ST > {1'b0, tgt_mag} ? tgt_mag : duty_out + ST[DUTY_W-1:0];
   assign dn_v = {1'b0, duty_out} < {1'b0, tgt_mag} + ST ? tgt_mag : duty_out - ST[DUTY_W-1:0];
   assign dz_v = {1'b0, duty_out} < ST ? '0 : duty_out - ST[DUTY_W-1:0];
   always_comb begin
      state_nx = state;
      duty_nx = duty_out;
      dir_nx = dir_out;
      tgt_mag_nx = tgt_mag;
      tgt_dir_nx = tgt_dir;
      dead_nx = dead_cnt;
      if (wdog_hit) tgt_mag_nx = '0;
      if (accept) begin
         tgt_mag_nx = sat_abs(cmd.cmd_speed, DUTY_MAX);
         tgt_dir_nx = cmd.cmd_speed == '0 ? tgt_dir : cmd.cmd_speed[DUTY_W-1];
      end
      if (estop) begin
         duty_nx = '0;
         tgt_mag_nx = '0;
         state_nx = RUN;
      end else if (state == DEAD) begin
         duty_nx = '0;
         dead_nx = dead_cnt + 1'b1;
         if (dead_cnt == DW'(DEAD_CYCLES - 1)) begin
            dir_nx = tgt_dir;
            state_nx = RUN;
         end
      end else begin
         if (tick) duty_nx = tgt_dir == dir_out ? (duty_out < tgt_mag ? up_v : dn_v) : dz_v;
         // Direction only changes once duty has reached zero, tested every clock.
         if (tgt_dir != dir_out && duty_out == '0) begin
            state_nx = DEAD;
            dead_nx = '0;
         end
      end
   end
   always_ff @(posedge CLK100MHZ or posedge rst)
      if (rst) begin
         state <= RUN;
         duty_out <= '0;
         dir_out <= 1'b0;
         tgt_mag <= '0;
         tgt_dir <= 1'b0;
         dead_cnt <= '0;
      end else begin
         state <= state_nx;
         duty_out <= duty_nx;
         dir_out <= dir_nx;
         tgt_mag <= tgt_mag_nx;
         tgt_dir <= tgt_dir_nx;
         dead_cnt <= dead_nx;
      end
`ifdef PWM_RAMP_WDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES + 1);
   logic [WW-1:0] wdog_cnt;
   // Counter parks at the limit so the target stays forced to zero until a new command arrives.
   assign wdog_hit = wdog_cnt == WW'(WDOG_CYCLES - 1);
   always_ff @(posedge CLK100MHZ or posedge rst)
      if (rst) begin
         wdog_cnt <= '0;
         wdog_fault <= 1'b0;
      end else if (accept) begin
         wdog_cnt <= '0;
         wdog_fault <= 1'b0;
      end else if (wdog_hit) wdog_fault <= 1'b1;
      else wdog_cnt <= wdog_cnt + 1'b1;
`else
   assign wdog_hit = 1'b0;
   assign wdog_fault = 1'b0;
`endif
endmodule
